// File: rtl/usb_pkg.sv
// Shared constants and enums for the parametrised USB serial CRC engine.
package usb_pkg;

   localparam logic [4:0]  CRC5_POLY      = 5'h05;
   localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   typedef enum logic {
      CRC_GEN   = 1'b0,
      CRC_CHECK = 1'b1
   } crc_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_APPEND = 2'd2,
      ST_RESULT = 2'd3
   } crc_state_t;

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit-step of a left-shifting CRC register; fb_i selects whether POLY is folded in.
module crc_lfsr_step #(
   parameter int unsigned     W    = 16,
   parameter logic [W-1:0]    POLY = W'(16'h8005)
) (
   input  logic [W-1:0] crc_i,
   input  logic         fb_i,
   output logic [W-1:0] crc_o
);

   assign crc_o = {crc_i[W-2:0], 1'b0} ^ (fb_i ? POLY : '0);

endmodule

// File: rtl/usb_crc_engine.sv
// Serial CRC generator/checker for USB token (CRC5) and data (CRC16) packets.
// Optional USB_CRC_ABORT_EN adds an abort input that returns the engine to IDLE.
module usb_crc_engine
   import usb_pkg::*;
#(
   parameter int unsigned  W        = 16,
   parameter logic [W-1:0] POLY     = W'(CRC16_POLY),
   parameter logic [W-1:0] RESIDUAL = W'(CRC16_RESIDUAL)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mode,
   input  logic start,
   input  logic s_in,
   input  logic s_valid,
   input  logic endr,
   input  logic pause,
`ifdef USB_CRC_ABORT_EN
   input  logic abort,
`endif
   output logic s_out,
   output logic s_out_valid,
   output logic busy,
   output logic done,
   output logic crc_ok,
   output logic crc_err
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   crc_state_t    state_q;
   crc_mode_t     mode_q;
   logic [W-1:0]  crc_q;
   logic [W-1:0]  crc_d;
   logic [CW-1:0] cnt_q;
   logic          s_out_q;
   logic          s_out_valid_q;
   logic          busy_q;
   logic          done_q;
   logic          crc_ok_q;
   logic          crc_err_q;
   logic          fb_c;
   logic          abort_c;

`ifdef USB_CRC_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   // APPEND shifts the register out with zero feedback
   assign fb_c = (state_q == ST_SHIFT) & (s_in ^ crc_q[W-1]);

   crc_lfsr_step #(
      .W    (W),
      .POLY (POLY)
   ) u_step (
      .crc_i (crc_q),
      .fb_i  (fb_c),
      .crc_o (crc_d)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q       <= ST_IDLE;
         mode_q        <= CRC_GEN;
         crc_q         <= '1;
         cnt_q         <= '0;
         s_out_q       <= 1'b0;
         s_out_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         crc_ok_q      <= 1'b0;
         crc_err_q     <= 1'b0;
      end else if (abort_c) begin
         state_q       <= ST_IDLE;
         s_out_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         crc_ok_q      <= 1'b0;
         crc_err_q     <= 1'b0;
      end else if (!pause) begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               s_out_valid_q <= 1'b0;
               if (start) begin
                  crc_q     <= '1;
                  mode_q    <= crc_mode_t'(mode);
                  crc_ok_q  <= 1'b0;
                  crc_err_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               s_out_valid_q <= s_valid;
               if (s_valid) begin
                  s_out_q <= s_in;
                  crc_q   <= crc_d;
                  if (endr) begin
                     if (mode_q == CRC_GEN) begin
                        cnt_q   <= CW'(W - 1);
                        state_q <= ST_APPEND;
                     end else begin
                        state_q <= ST_RESULT;
                     end
                  end
               end
            end
            ST_APPEND: begin
               s_out_q       <= ~crc_q[W-1];
               s_out_valid_q <= 1'b1;
               crc_q         <= crc_d;
               cnt_q         <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RESULT: begin
               s_out_valid_q <= 1'b0;
               crc_ok_q      <= (crc_q == RESIDUAL);
               crc_err_q     <= (crc_q != RESIDUAL);
               done_q        <= 1'b1;
               busy_q        <= 1'b0;
               state_q       <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_out       = s_out_q;
   assign s_out_valid = s_out_valid_q;
   assign busy        = busy_q;
   // a pending done pulse is held back while the stuffer stalls
   assign done        = done_q & ~pause;
   assign crc_ok      = crc_ok_q;
   assign crc_err     = crc_err_q;

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine: CRC5 token and CRC16 data cases, check mode, pause, reset.
module tb_usb_crc_engine;
   import usb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, mode, start, s_in, s_valid, endr, pause, abort;
   logic o5, v5, b5, d5, ok5, er5;
   logic o16, v16, b16, d16, ok16, er16;
   logic sel16;
   logic cur_out, cur_valid, cur_busy, cur_done, cur_ok, cur_err;

   int n_checks = 0;
   int n_pass   = 0;

   usb_crc_engine #(.W(5), .POLY(CRC5_POLY), .RESIDUAL(CRC5_RESIDUAL)) u_crc5 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .s_in(s_in),
      .s_valid(s_valid), .endr(endr), .pause(pause),
`ifdef USB_CRC_ABORT_EN
      .abort(abort),
`endif
      .s_out(o5), .s_out_valid(v5), .busy(b5), .done(d5), .crc_ok(ok5), .crc_err(er5)
   );

   usb_crc_engine #(.W(16), .POLY(CRC16_POLY), .RESIDUAL(CRC16_RESIDUAL)) u_crc16 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .s_in(s_in),
      .s_valid(s_valid), .endr(endr), .pause(pause),
`ifdef USB_CRC_ABORT_EN
      .abort(abort),
`endif
      .s_out(o16), .s_out_valid(v16), .busy(b16), .done(d16), .crc_ok(ok16), .crc_err(er16)
   );

   assign cur_out   = sel16 ? o16  : o5;
   assign cur_valid = sel16 ? v16  : v5;
   assign cur_busy  = sel16 ? b16  : b5;
   assign cur_done  = sel16 ? d16  : d5;
   assign cur_ok    = sel16 ? ok16 : ok5;
   assign cur_err   = sel16 ? er16 : er5;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generate-mode packet; optional pause window counted in cycles after the last payload bit
   task automatic gen_packet(input string tag, input logic [31:0] pay, input int nbits,
                             input int w, input logic [15:0] exp_crc,
                             input int p_at, input int p_len);
      logic [31:0] obs;
      logic [15:0] crc_obs;
      logic        prev_out, prev_val;
      int          got, gaps, stalls, ndone, done_cyc, cyc;
      obs = '0; crc_obs = '0;
      got = 0; gaps = 0; stalls = 0; ndone = 0; done_cyc = -1; cyc = 0;
      mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("%s busy", tag), 32'(cur_busy), 32'd1);
      for (int i = 0; i < nbits; i++) begin
         s_in = pay[i]; s_valid = 1'b1; endr = (i == nbits - 1);
         tick();
         obs[i] = cur_out;
         if (!cur_valid) gaps++;
      end
      s_valid = 1'b0; endr = 1'b0; s_in = 1'b0;
      prev_out = cur_out; prev_val = cur_valid;
      while (got < w && cyc < 64) begin
         pause = (p_len > 0) && (cyc >= p_at) && (cyc < p_at + p_len);
         tick();
         cyc++;
         if (pause) begin
            if (cur_out !== prev_out || cur_valid !== prev_val) stalls++;
         end else if (cur_valid) begin
            crc_obs = {crc_obs[14:0], cur_out};
            got++;
         end else begin
            gaps++;
         end
         if (cur_done) begin
            ndone++;
            done_cyc = cyc;
         end
         prev_out = cur_out; prev_val = cur_valid;
      end
      pause = 1'b0;
      check($sformatf("%s payload", tag), obs, pay);
      check($sformatf("%s crc", tag), 32'(crc_obs), 32'(exp_crc));
      check($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'(w + p_len));
      check($sformatf("%s done_count", tag), 32'(ndone), 32'd1);
      check($sformatf("%s gaps", tag), 32'(gaps), 32'd0);
      check($sformatf("%s stall_moves", tag), 32'(stalls), 32'd0);
      tick();
      check($sformatf("%s end_valid", tag), 32'(cur_valid), 32'd0);
      check($sformatf("%s end_done", tag), 32'(cur_done), 32'd0);
      check($sformatf("%s end_busy", tag), 32'(cur_busy), 32'd0);
      repeat (24) tick();
   endtask

   // Check-mode packet: result visible two cycles after the last accepted bit
   task automatic chk_packet(input string tag, input logic [47:0] bits, input int nbits,
                             input logic exp_ok);
      mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         s_in = bits[i]; s_valid = 1'b1; endr = (i == nbits - 1);
         tick();
      end
      s_valid = 1'b0; endr = 1'b0; s_in = 1'b0;
      check($sformatf("%s early_done", tag), 32'(cur_done), 32'd0);
      tick();
      check($sformatf("%s done", tag), 32'(cur_done), 32'd1);
      check($sformatf("%s crc_ok", tag), 32'(cur_ok), 32'(exp_ok));
      check($sformatf("%s crc_err", tag), 32'(cur_err), 32'(!exp_ok));
      tick();
      check($sformatf("%s done_pulse", tag), 32'(cur_done), 32'd0);
      check($sformatf("%s ok_held", tag), 32'(cur_ok), 32'(exp_ok));
      repeat (24) tick();
   endtask

   initial begin
      logic [47:0] stream;
      logic [15:0] crc16_val;
      int          ndone;
      sel16 = 1'b1;
      rst_n = 1'b1; mode = 1'b0; start = 1'b0; s_in = 1'b0;
      s_valid = 1'b0; endr = 1'b0; pause = 1'b0; abort = 1'b0;
      repeat (2) tick();
      check("rst s_out", 32'(cur_out), 32'd0);
      check("rst valid", 32'(cur_valid), 32'd0);
      check("rst busy", 32'(cur_busy), 32'd0);
      check("rst done", 32'(cur_done), 32'd0);
      check("rst ok_err", 32'({cur_ok, cur_err}), 32'd0);
      rst_n = 1'b0;
      tick();

      // token: addr 0x15 then endp 0xE, LSB-first -> {endp, addr}
      sel16 = 1'b0;
      gen_packet("crc5_token", 32'h0000_0715, 11, 5, 16'h0017, 0, 0);

      sel16 = 1'b1;
      gen_packet("crc16_gen", 32'h0302_0100, 32, 16, 16'hF75E, 0, 0);

      crc16_val = 16'hF75E;
      stream = '0;
      stream[31:0] = 32'h0302_0100;
      for (int j = 0; j < 16; j++) stream[32 + j] = crc16_val[15 - j];
      chk_packet("crc16_good", stream, 48, 1'b1);
      chk_packet("crc16_bad", stream ^ 48'h80, 48, 1'b0);

      gen_packet("crc16_pause", 32'h0302_0100, 32, 16, 16'hF75E, 5, 3);

      // synchronous reset in the middle of the payload
      mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_in = 1'b1; s_valid = 1'b1;
         tick();
      end
      check("pre_rst s_out", 32'({cur_out, cur_valid, cur_busy}), 32'd7);
      rst_n = 1'b1;
      tick();
      check("mid_rst outs", 32'({cur_out, cur_valid, cur_busy, cur_done, cur_ok, cur_err}), 32'd0);
      rst_n = 1'b0; s_valid = 1'b0; s_in = 1'b0;
      tick();
      check("post_rst busy", 32'(cur_busy), 32'd0);

      sel16 = 1'b0;
      gen_packet("crc5_after_rst", 32'h0000_0715, 11, 5, 16'h0017, 0, 0);

`ifdef USB_CRC_ABORT_EN
      sel16 = 1'b1;
      mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         s_in = stream[i]; s_valid = 1'b1; endr = (i == 31);
         tick();
      end
      s_valid = 1'b0; endr = 1'b0; s_in = 1'b0;
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort valid", 32'(cur_valid), 32'd0);
      check("abort busy", 32'(cur_busy), 32'd0);
      ndone = 0;
      for (int i = 0; i < 24; i++) begin
         if (cur_done) ndone++;
         tick();
      end
      check("abort no_done", 32'(ndone), 32'd0);
`else
      ndone = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_crc_engine.md
# usb_crc_engine

Parametrised serial CRC generator/checker for the USB serial datapath, replacing the fixed CRC5/CRC16 pair. It sits between the packet encoder and the bit stuffer on transmit, and after the bit unstuffer on receive. In generate mode it passes payload bits through and appends the complemented CRC MSB-first. In check mode it compares the final register against the residual and flags the result. Width, polynomial and residual are parameters; one RTL body serves token (CRC5) and data (CRC16) packets.

## Interface
- W, 16, CRC width (5 or 16 used)
- POLY, 16'h8005, generator polynomial without x^W term (CRC5: 5'h05)
- RESIDUAL, 16'h800D, good-packet residual in check mode (CRC5: 5'h0C)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous and active-high (asserted = 1)
- mode  in  1  0 = generate, 1 = check; sampled on start
- start  in  1  begin packet; CRC register loads all-ones
- s_in  in  1  serial payload bit, LSB-first per byte
- s_valid  in  1  s_in valid this cycle
- endr  in  1  qualifies the last payload bit (with s_valid)
- pause  in  1  downstream stall from bit stuffer; freezes all state
- s_out  out  1  registered serial output (payload, then CRC)
- s_out_valid  out  1  s_out carries a bit this cycle
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at packet completion
- crc_ok / crc_err  out  1 each  check-mode result, held until next start

## Operation
- States: IDLE, SHIFT, APPEND, RESULT.
- IDLE: start -> crc = all-ones, latch mode, go SHIFT. endr/s_valid ignored.
- SHIFT, accepted bit (s_valid & !pause): fb = s_in ^ crc[W-1]; crc = {crc[W-2:0],1'b0} ^ (fb ? POLY : 0). s_out <= s_in, s_out_valid <= 1.
- SHIFT with accepted bit and endr: generate -> APPEND with count = W-1. Check -> RESULT.
- APPEND: each non-paused cycle, s_out <= ~crc[W-1], crc shifts left by 1, count decrements. count = 0 -> IDLE with done.
- RESULT (one cycle): crc_ok <= (crc == RESIDUAL), crc_err <= ~that, done = 1 -> IDLE.
- pause high: state, crc, count, s_out and s_out_valid hold. done is never asserted while pause is high; it is deferred.
- start while busy: ignored. s_valid low in SHIFT: s_out_valid <= 0, crc holds.
- Zero-length payload is not representable; packet framing always carries at least one bit before endr (PID excluded upstream).

## Timing
- Reset values: s_out 0, s_out_valid 0, busy 0, done 0, crc_ok 0, crc_err 0, state IDLE, crc all-ones. rst_n mid-packet aborts with no done.
- Payload bit accepted at edge k is visible on s_out in cycle k+1 (1-cycle latency).
- Generate, no pause: last payload bit accepted at edge k. CRC bit i (MSB i = 0) is on s_out in cycle k+2+i, contiguous with the payload. done is high in the same cycle as CRC bit W-1.
- Check: last bit accepted at edge k. done, crc_ok and crc_err are valid in cycle k+2.
- Each pause cycle adds exactly one cycle to all subsequent timing.

## Configuration
- USB_CRC_ABORT_EN defined: adds input abort (1 bit). Abort high in any state -> IDLE next edge. s_out_valid drops, no done, crc_ok and crc_err cleared. Abort has priority over pause and start.
- Undefined: no abort port; only rst_n terminates a packet.

## Structure
- usb_pkg holds: CRC5_POLY, CRC5_RESIDUAL, CRC16_POLY, CRC16_RESIDUAL constants; crc_mode_t enum (CRC_GEN, CRC_CHECK); crc_state_t enum.
- One sub-module, crc_lfsr_step #(W, POLY): combinational next-value function, instantiated once and shared by SHIFT and APPEND (APPEND feeds fb = 0).

## Test plan
- CRC5 generate: 11-bit token field, addr 0x15, endp 0xE, LSB-first -> appended bits 5'b10111 (0x17) MSB-first; done with the 5th CRC bit.
- CRC16 generate: bytes 00 01 02 03 -> CRC16 0xF75E, sent as 16 bits MSB-first, immediately after the 32nd payload bit.
- CRC16 check: same 32 bits plus correct CRC -> crc_ok = 1. Flip payload bit 7 -> crc_err = 1, crc_ok = 0.
- Pause: assert pause for 3 cycles mid-APPEND of the CRC16 case -> identical bit sequence; done delayed exactly 3 cycles; no s_out change while paused.
- rst_n high mid-SHIFT -> next cycle all outputs at reset values. Then a fresh start produces the correct 0x17 token case.
- With USB_CRC_ABORT_EN: abort during APPEND -> s_out_valid 0 next cycle, no done pulse, busy 0.
